// File: rtl/ram_pkg.sv
// Shared constants and types for the RAM port arbiter slice.
package ram_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 8;

  // Requester index: 0 or 1.
  typedef logic port_id_t;

  // Tag carried alongside each accepted read until its response is delivered.
  typedef struct packed {
    logic     valid;
    port_id_t port;
    logic     err;
  } rd_tag_t;

  // True when the address maps onto an implemented RAM location.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (int'(addr) < DEPTH);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Request/response bus of both requesters plus the RAM pins, as seen by the arbiter.
interface ram_port_arbiter_if;
  import ram_pkg::*;

  // Handshake: a request transfers in a cycle where req_valid and req_ready are both
  // high; while valid is high and ready low the requester holds write/addr/wdata stable.
  // Responses are single-cycle rsp_valid pulses with no back-pressure.
  logic              p0_req_valid;
  logic              p0_req_ready;
  logic              p0_req_write;
  logic [ADDR_W-1:0] p0_req_addr;
  logic [DATA_W-1:0] p0_req_wdata;
  logic              p0_rsp_valid;
  logic [DATA_W-1:0] p0_rsp_rdata;
  logic              p0_rsp_err;

  logic              p1_req_valid;
  logic              p1_req_ready;
  logic              p1_req_write;
  logic [ADDR_W-1:0] p1_req_addr;
  logic [DATA_W-1:0] p1_req_wdata;
  logic              p1_rsp_valid;
  logic [DATA_W-1:0] p1_rsp_rdata;
  logic              p1_rsp_err;

  logic              ram_wr_enb;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_rd_enb;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_data_out;

  // Round-robin pointer, exposed for observation only.
  port_id_t          dbg_rr_ptr;

  modport slave (
    input  p0_req_valid, p0_req_write, p0_req_addr, p0_req_wdata,
    input  p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata,
    input  ram_data_out,
    output p0_req_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
    output p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
    output ram_wr_enb, ram_wr_addr, ram_data_in, ram_rd_enb, ram_rd_addr,
    output dbg_rr_ptr
  );

  modport master (
    output p0_req_valid, p0_req_write, p0_req_addr, p0_req_wdata,
    output p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata,
    output ram_data_out,
    input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
    input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
    input  ram_wr_enb, ram_wr_addr, ram_data_in, ram_rd_enb, ram_rd_addr,
    input  dbg_rr_ptr
  );

endinterface

// File: rtl/ram_rr_arb.sv
// Two-way round-robin grant logic. A write and a read from different ports are both
// granted; same-type contention goes to the pointer's port and rotates the pointer.
module ram_rr_arb
  import ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic [1:0] write,
  output logic [1:0] gnt_wr,
  output logic [1:0] gnt_rd,
  output port_id_t   o_ptr
);

  port_id_t   r_ptr;
  port_id_t   w_ptr_nxt;
  logic       w_contend;
  logic [1:0] w_sel;

  assign w_contend = (&valid) & (write[0] == write[1]);
  assign o_ptr     = r_ptr;

  // Pointer register; port 0 has priority out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= 1'b0;
    else     r_ptr <= w_ptr_nxt;
  end

  // Rotate to the other port only after a same-type contention.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_contend) w_ptr_nxt = ~r_ptr;
  end

  // Grant decode: single or dual issue passes valid through; contention picks one.
  always_comb begin
    w_sel = valid;
    if (w_contend) w_sel = r_ptr ? 2'b10 : 2'b01;
    if (rst)       w_sel = 2'b00;
    gnt_wr = w_sel & write;
    gnt_rd = w_sel & ~write;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter/sequencer in front of the 8 x 32 RAM: drives the RAM write and read
// ports from granted requests and returns read data two cycles after acceptance.
// Optional build macro RAM_ARB_ADDR_CHECK_EN: addresses >= DEPTH are accepted but not
// forwarded; such reads answer rdata 0 with rsp_err 1, such writes are dropped.
module ram_port_arbiter
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  logic [1:0]        w_gnt_wr;
  logic [1:0]        w_gnt_rd;
  port_id_t          w_ptr;
  port_id_t          w_wr_port;
  port_id_t          w_rd_port;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_wr_go;
  logic              w_rd_go;
  rd_tag_t           w_tag;
  rd_tag_t           r_tag1;
  logic [DATA_W-1:0] w_rsp_data;

  logic              r_p0_rsp_valid;
  logic              r_p1_rsp_valid;
  logic [DATA_W-1:0] r_p0_rsp_rdata;
  logic [DATA_W-1:0] r_p1_rsp_rdata;
  logic              r_p0_rsp_err;
  logic              r_p1_rsp_err;

  ram_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({bus.p1_req_valid, bus.p0_req_valid}),
    .write  ({bus.p1_req_write, bus.p0_req_write}),
    .gnt_wr (w_gnt_wr),
    .gnt_rd (w_gnt_rd),
    .o_ptr  (w_ptr)
  );

  assign bus.p0_req_ready = w_gnt_wr[0] | w_gnt_rd[0];
  assign bus.p1_req_ready = w_gnt_wr[1] | w_gnt_rd[1];
  assign bus.dbg_rr_ptr   = w_ptr;

  // Pick the granted write and read sources; at most one of each per cycle.
  always_comb begin
    w_wr_port = w_gnt_wr[1];
    w_rd_port = w_gnt_rd[1];
    w_wr_addr = w_wr_port ? bus.p1_req_addr  : bus.p0_req_addr;
    w_wr_data = w_wr_port ? bus.p1_req_wdata : bus.p0_req_wdata;
    w_rd_addr = w_rd_port ? bus.p1_req_addr  : bus.p0_req_addr;
`ifdef RAM_ARB_ADDR_CHECK_EN
    w_wr_ok   = addr_in_range(w_wr_addr);
    w_rd_ok   = addr_in_range(w_rd_addr);
`else
    w_wr_ok   = 1'b1;
    w_rd_ok   = 1'b1;
`endif
    w_wr_go   = (|w_gnt_wr) & w_wr_ok;
    w_rd_go   = (|w_gnt_rd) & w_rd_ok;
    w_tag     = '{valid: (|w_gnt_rd), port: w_rd_port, err: (|w_gnt_rd) & ~w_rd_ok};
  end

  // RAM pins stay at zero whenever the corresponding enable is low.
  assign bus.ram_wr_enb  = w_wr_go;
  assign bus.ram_wr_addr = w_wr_go ? w_wr_addr : '0;
  assign bus.ram_data_in = w_wr_go ? w_wr_data : '0;
  assign bus.ram_rd_enb  = w_rd_go;
  assign bus.ram_rd_addr = w_rd_go ? w_rd_addr : '0;

  // Stage 1: tag travels with the RAM access while the RAM registers its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tag1 <= '0;
    else     r_tag1 <= w_tag;
  end

  // Rejected addresses answer with zero data instead of whatever the RAM holds.
  assign w_rsp_data = r_tag1.err ? '0 : bus.ram_data_out;

  // Stage 2: pulse valid on the tagged port; data and err hold between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p0_rsp_valid <= 1'b0;
      r_p1_rsp_valid <= 1'b0;
      r_p0_rsp_rdata <= '0;
      r_p1_rsp_rdata <= '0;
      r_p0_rsp_err   <= 1'b0;
      r_p1_rsp_err   <= 1'b0;
    end else begin
      r_p0_rsp_valid <= r_tag1.valid & (r_tag1.port == 1'b0);
      r_p1_rsp_valid <= r_tag1.valid & (r_tag1.port == 1'b1);
      if (r_tag1.valid && r_tag1.port == 1'b0) begin
        r_p0_rsp_rdata <= w_rsp_data;
        r_p0_rsp_err   <= r_tag1.err;
      end
      if (r_tag1.valid && r_tag1.port == 1'b1) begin
        r_p1_rsp_rdata <= w_rsp_data;
        r_p1_rsp_err   <= r_tag1.err;
      end
    end
  end

  assign bus.p0_rsp_valid = r_p0_rsp_valid;
  assign bus.p0_rsp_rdata = r_p0_rsp_rdata;
  assign bus.p0_rsp_err   = r_p0_rsp_err;
  assign bus.p1_rsp_valid = r_p1_rsp_valid;
  assign bus.p1_rsp_rdata = r_p1_rsp_rdata;
  assign bus.p1_rsp_err   = r_p1_rsp_err;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a behavioural 8 x 32 registered-read RAM sits on
// the RAM pins, request vectors carry hand-computed ready patterns and read data, and
// a negedge monitor pops the expected-response queues.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cyc = '0;

  int n_vec = 0;
  int n_err = 0;
  int n_rsp = 0;

  // {due cycle[15:0], err, rdata[31:0]}
  logic [48:0] exp_q0[$];
  logic [48:0] exp_q1[$];

  logic [31:0] ram_q = '0;
  logic [31:0] mem [8];

`ifdef RAM_ARB_ADDR_CHECK_EN
  localparam bit          ADDR_CHECK = 1'b1;
  localparam logic [31:0] X_A9       = 32'h0000_0000;
  localparam logic [31:0] X_A4       = 32'h4444_4444;
`else
  // Unchecked addresses reach the RAM, which decodes only the low three bits.
  localparam bit          ADDR_CHECK = 1'b0;
  localparam logic [31:0] X_A9       = 32'hA0A0_A0A1;
  localparam logic [31:0] X_A4       = 32'hCCCC_CCCC;
`endif

  localparam logic [37:0] NONE = '0;

  ram_port_arbiter_if bus();

  ram_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // RAM model: registered read, read-before-write on the same edge
  always @(posedge clk) begin
    if (bus.ram_rd_enb) ram_q <= mem[bus.ram_rd_addr[2:0]];
    if (bus.ram_wr_enb) mem[bus.ram_wr_addr[2:0]] <= bus.ram_data_in;
  end
  assign bus.ram_data_out = ram_q;

  function automatic logic bad(input logic [3:0] a);
    return ADDR_CHECK && (a >= 4'd8);
  endfunction

  function automatic logic [37:0] rd(input logic [3:0] a);
    return {2'b10, a, 32'h0};
  endfunction

  function automatic logic [37:0] wr(input logic [3:0] a, input logic [31:0] d);
    return {2'b11, a, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [37:0] r0, input logic [37:0] r1);
    {bus.p0_req_valid, bus.p0_req_write, bus.p0_req_addr, bus.p0_req_wdata} = r0;
    {bus.p1_req_valid, bus.p1_req_write, bus.p1_req_addr, bus.p1_req_wdata} = r1;
  endtask

  // One request cycle: er = expected {p1,p0} ready; x0/x1 = expected read data.
  task automatic apply(input logic [37:0] r0, input logic [37:0] r1, input logic [1:0] er,
                       input logic [31:0] x0, input logic [31:0] x1);
    logic        e_we, e_re;
    logic [3:0]  e_wa, e_ra;
    logic [31:0] e_wd;
    drive(r0, r1);
    @(negedge clk);
    check("ready", 64'({bus.p1_req_ready, bus.p0_req_ready}), 64'(er));
    e_we = 1'b0; e_wa = '0; e_wd = '0; e_re = 1'b0; e_ra = '0;
    if (er[0] && r0[36] && !bad(r0[35:32])) {e_we, e_wa, e_wd} = {1'b1, r0[35:0]};
    if (er[1] && r1[36] && !bad(r1[35:32])) {e_we, e_wa, e_wd} = {1'b1, r1[35:0]};
    if (er[0] && !r0[36] && !bad(r0[35:32])) {e_re, e_ra} = {1'b1, r0[35:32]};
    if (er[1] && !r1[36] && !bad(r1[35:32])) {e_re, e_ra} = {1'b1, r1[35:32]};
    check("ram_drive",
          64'({bus.ram_wr_enb, bus.ram_wr_addr, bus.ram_data_in, bus.ram_rd_enb, bus.ram_rd_addr}),
          64'({e_we, e_wa, e_wd, e_re, e_ra}));
    if (er[0] && !r0[36]) exp_q0.push_back({cyc + 16'd2, bad(r0[35:32]), x0});
    if (er[1] && !r1[36]) exp_q1.push_back({cyc + 16'd2, bad(r1[35:32]), x1});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(NONE, NONE);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Asynchronous reset with whatever requests are currently presented.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ctrl",
          64'({bus.p0_req_ready, bus.p1_req_ready, bus.p0_rsp_valid, bus.p1_rsp_valid,
               bus.p0_rsp_err, bus.p1_rsp_err, bus.ram_wr_enb, bus.ram_rd_enb,
               bus.dbg_rr_ptr, bus.ram_wr_addr, bus.ram_rd_addr}), 64'd0);
    check("rst_rdata", {bus.p0_rsp_rdata, bus.p1_rsp_rdata}, 64'd0);
    check("rst_din", 64'(bus.ram_data_in), 64'd0);
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(NONE, NONE);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : mon
    logic [48:0] e;
    if (!rst) begin
      if (bus.p0_rsp_valid) begin
        n_rsp++;
        if (exp_q0.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL p0_rsp: unexpected response rdata %h err %b, none required",
                   bus.p0_rsp_rdata, bus.p0_rsp_err);
        end else begin
          e = exp_q0.pop_front();
          check("p0_rsp", 64'({cyc, bus.p0_rsp_err, bus.p0_rsp_rdata}), 64'(e));
        end
      end
      if (bus.p1_rsp_valid) begin
        n_rsp++;
        if (exp_q1.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL p1_rsp: unexpected response rdata %h err %b, none required",
                   bus.p1_rsp_rdata, bus.p1_rsp_err);
        end else begin
          e = exp_q1.pop_front();
          check("p1_rsp", 64'({cyc, bus.p1_rsp_err, bus.p1_rsp_rdata}), 64'(e));
        end
      end
    end
  end

  initial begin
    int seen;
    drive(rd(4'd0), NONE);
    do_reset();

    // single port write then read
    apply(wr(4'd3, 32'hDEAD_BEEF), NONE, 2'b01, '0, '0);
    apply(rd(4'd3), NONE, 2'b01, 32'hDEAD_BEEF, '0);
    apply(NONE, wr(4'd1, 32'hA0A0_A0A1), 2'b10, '0, '0);
    apply(wr(4'd2, 32'hB0B0_B0B2), NONE, 2'b01, '0, '0);
    apply(wr(4'd5, 32'h1111_1111), NONE, 2'b01, '0, '0);
    idle(3);

    // contention from reset: p0, p1, p0, p1
    do_reset();
    apply(rd(4'd1), rd(4'd2), 2'b01, 32'hA0A0_A0A1, '0);
    apply(rd(4'd3), rd(4'd2), 2'b10, '0, 32'hB0B0_B0B2);
    apply(rd(4'd3), rd(4'd5), 2'b01, 32'hDEAD_BEEF, '0);
    apply(rd(4'd1), rd(4'd5), 2'b10, '0, 32'h1111_1111);
    apply(rd(4'd1), NONE, 2'b01, 32'hA0A0_A0A1, '0);

    // dual issue on the same address returns pre-write contents
    apply(wr(4'd5, 32'h2222_2222), rd(4'd5), 2'b11, '0, 32'h1111_1111);
    apply(NONE, rd(4'd5), 2'b10, '0, 32'h2222_2222);

    // stall: p1 held through a lost cycle, wins the next contention
    apply(rd(4'd2), rd(4'd3), 2'b01, 32'hB0B0_B0B2, '0);
    apply(rd(4'd1), rd(4'd3), 2'b10, '0, 32'hDEAD_BEEF);
    apply(rd(4'd1), NONE, 2'b01, 32'hA0A0_A0A1, '0);

    // write contention and read-back
    apply(wr(4'd6, 32'h6666_6666), wr(4'd7, 32'h7777_7777), 2'b01, '0, '0);
    apply(wr(4'd4, 32'h4444_4444), wr(4'd7, 32'h7777_7777), 2'b10, '0, '0);
    apply(wr(4'd4, 32'h4444_4444), NONE, 2'b01, '0, '0);
    apply(rd(4'd6), rd(4'd7), 2'b01, 32'h6666_6666, '0);
    apply(rd(4'd4), rd(4'd7), 2'b10, '0, 32'h7777_7777);
    apply(rd(4'd4), NONE, 2'b01, 32'h4444_4444, '0);

    // addresses beyond the implemented depth
    apply(rd(4'd9), NONE, 2'b01, X_A9, '0);
    apply(NONE, wr(4'd12, 32'hCCCC_CCCC), 2'b10, '0, '0);
    apply(rd(4'd4), NONE, 2'b01, X_A4, '0);
    idle(3);

    // reset mid-burst: in-flight read must never respond, pointer returns to port 0
    apply(rd(4'd3), rd(4'd5), 2'b01, 32'hDEAD_BEEF, '0);
    drive(rd(4'd6), rd(4'd5));
    do_reset();
    seen = n_rsp;
    idle(4);
    check("no_rsp_after_rst", 64'(n_rsp - seen), 64'd0);
    apply(rd(4'd3), rd(4'd5), 2'b01, 32'hDEAD_BEEF, '0);
    apply(rd(4'd6), rd(4'd5), 2'b10, '0, 32'h2222_2222);
    apply(rd(4'd6), NONE, 2'b01, 32'h6666_6666, '0);

    idle(4);
    check("drain", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-port round-robin arbiter and sequencer for the shared 8 x 32 single-clock RAM. It accepts read/write requests from two independent requesters over valid/ready handshakes and drives the RAM's separate write and read ports. It returns read data to the owning requester with fixed latency. It sits directly in front of the RAM instance; requesters never touch the RAM pins.

## Interface
- DATA_W, 32, data width
- ADDR_W, 4, address width (matches RAM address pins)
- DEPTH, 8, implemented RAM locations
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- pN_req_valid  in  1  request valid, N = 0, 1
- pN_req_ready  out  1  request accepted this cycle
- pN_req_write  in  1  1 = write, 0 = read
- pN_req_addr  in  ADDR_W  request address
- pN_req_wdata  in  DATA_W  write data
- pN_rsp_valid  out  1  read response valid (one-cycle pulse)
- pN_rsp_rdata  out  DATA_W  read data
- pN_rsp_err  out  1  response flags an out-of-range address
- ram_wr_enb, ram_wr_addr[ADDR_W], ram_data_in[DATA_W]  out  RAM write port
- ram_rd_enb, ram_rd_addr[ADDR_W]  out  RAM read port
- ram_data_out  in  DATA_W  RAM registered read data

## Operation
- A handshake completes when valid and ready are both high in the same cycle.
- Requesters must hold the request fields stable while valid is high and ready is low.
- pN_req_ready is combinational from both valids, both write bits and the rotation pointer.
- **Single grant:** if only one port is valid, grant it.
- **Contention:** if both ports are valid with the same type (both read or both write), grant the port the pointer selects.
  - After such a grant, the pointer moves to the other port.
  - The pointer resets to port 0.
- **Dual issue:** if one port presents a write and the other a read, accept both in the same cycle and leave the pointer unchanged.
  - The read returns the pre-write contents, including when both target the same address.
- **RAM drive:** in the accept cycle, drive ram_wr_enb, ram_wr_addr and ram_data_in from the granted write, and ram_rd_enb and ram_rd_addr from the granted read.
  - With no grant, both enables are 0 and the address/data outputs are 0.
- **Writes:** a write produces no response.
- **Read pipeline:** each read carries a tag (port id, err) through a 2-stage pipeline. The response is delivered on the tagged port only.
- **Back-pressure:** responses cannot be stalled; there is no response ready.

## Timing
- A read accepted in cycle T drives the RAM in T. The RAM data is valid in T+1. The response is registered and asserted in T+2.
- Back-to-back reads give one response per cycle.
- Throughput is one grant per port-type per cycle.
- Reset values:
  - pN_req_ready = 0
  - pN_rsp_valid = 0, pN_rsp_rdata = 0, pN_rsp_err = 0
  - all RAM outputs = 0
  - pointer = port 0
  - pipeline tags invalid
- Reset asserted mid-operation:
  - discards in-flight reads; no response is ever emitted for them.
  - ready is low while rst is high.
  - ready may assert in the first cycle after deassertion.
- pN_rsp_valid is a single-cycle pulse per accepted read. Its rdata and err are valid only in that cycle; otherwise they hold their last value.

## Configuration
- **RAM_ARB_ADDR_CHECK_EN defined:** an address >= DEPTH is accepted normally but is not forwarded to the RAM (enable held 0).
  - Such a read returns rdata = 0 with rsp_err = 1 at T+2.
  - Such a write is silently dropped.
- **RAM_ARB_ADDR_CHECK_EN undefined:** all addresses are forwarded unchanged, and rsp_err is tied 0.

## Structure
- The shared package ram_pkg holds:
  - DATA_W, ADDR_W and DEPTH constants
  - a port_id_t typedef (1 bit)
  - a rd_tag_t packed struct {valid, port_id_t port, err}
- One sub-module, ram_rr_arb: the 2-way round-robin grant logic plus pointer register, with inputs valid[1:0] and write[1:0] and outputs gnt_wr[1:0] and gnt_rd[1:0].
- Everything else (RAM drive muxes, tag pipeline, response registers) stays in ram_port_arbiter.

## Test plan
- **Reset:** assert rst mid-burst. Require all outputs at reset values immediately, and no rsp_valid for in-flight reads.
- **Single port:** p0 writes 0xDEADBEEF to addr 3, then reads addr 3 (accepted in T). Require p0_rsp_valid at T+2 with rdata 0xDEADBEEF and p1_rsp_valid never high.
- **Contention:**
  - Both ports read continuously for 4 cycles from reset. Require grants p0, p1, p0, p1.
  - Each response must arrive at its own port, in order, 2 cycles after its grant.
- **Dual issue:** addr 5 holds 0x11111111. p0 writes 0x22222222 to addr 5 while p1 reads addr 5 in the same cycle.
  - Require both ready, and p1 rdata 0x11111111.
  - A following read of addr 5 must return 0x22222222.
- **Stall:** hold p1_req_valid with a read while p0 wins. Require p1 fields unchanged until accepted, and p1 granted on the next contended cycle.
- **Address check (RAM_ARB_ADDR_CHECK_EN):**
  - Read addr 9. Require ram_rd_enb = 0, rsp rdata 0 and rsp_err 1 at T+2.
  - A write to addr 12 must leave ram_wr_enb = 0.
